// File: rtl/blinken_render.sv
// Blinkenlight grid renderer: draws a grid of square cells from an internal
// on/off array, pixel-aligned with the incoming syncs. Once every FRAME_DIV
// frames, during vertical blank, a walk visits every cell and toggles some of
// them at random, driven by an LFSR.
//
//   state | meaning
//   IDLE  | waiting for a walk request from the frame counter
//   WALK  | visiting one cell per clock, toggling it when the LFSR allows
//   DONE  | one-clock tail after the last cell, then back to IDLE
module blinken_render #(
   parameter int          CELL_SHIFT = 5,
   parameter int          GRID_W     = 20,
   parameter int          GRID_H     = 15,
   parameter int          FRAME_DIV  = 30,
   parameter int          DENSITY    = 3,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter logic [7:0]  LIT_COLOR  = 8'hFC,
   parameter logic [7:0]  DARK_COLOR = 8'h04,
   parameter logic [7:0]  GRID_COLOR = 8'h49,
   parameter logic        HS_IDLE    = 1'b1,
   parameter logic        VS_IDLE    = 1'b1
) (
   input  logic        PIXEL_CLK,
   input  logic        RESET,
   input  logic [12:0] locX,
   input  logic [12:0] locY,
   input  logic        in_image,
   input  logic        sync_h,
   input  logic        sync_v,
   input  logic        freeze,
   output logic [7:0]  vga_rgb,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        updating
);

   localparam int NCELL = GRID_W * GRID_H;
   localparam int IW    = $clog2(NCELL);
   localparam int CW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam int RW    = (GRID_H > 1) ? $clog2(GRID_H) : 1;
   localparam int PW    = 13 - CELL_SHIFT;
   // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
   localparam logic [15:0]   SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [12:0]   TICK_Y = 13'(GRID_H << CELL_SHIFT);
   localparam logic [IW-1:0] LAST   = IW'(NCELL - 1);

   function automatic logic [NCELL-1:0] checker_init();
      logic [NCELL-1:0] v;
      v = '0;
      for (int r = 0; r < GRID_H; r++)
         for (int c = 0; c < GRID_W; c++)
            v[IW'(r * GRID_W + c)] = ((r ^ c) & 1) != 0;
      return v;
   endfunction

   localparam logic [NCELL-1:0] CHECKER = checker_init();

   typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_DONE} state_t;

   state_t           state_q, state_d;
   logic [NCELL-1:0] cells;
   logic [IW-1:0]    k;
   logic [15:0]      lfsr;
   logic [7:0]       frame_cnt;
   logic             tick, req, toggle;

   logic [PW-1:0]         col1, row1;
   logic [CELL_SHIFT-1:0] ox1, oy1;
   logic                  img1, hs1, vs1;
   logic                  in_grid, border, cell_bit;
   logic [IW-1:0]         idx;
   logic                  img2, grid2, border2, lit2, hs2, vs2;

   // S1: split the coordinates into cell number and offset within the cell.
   always_ff @(posedge PIXEL_CLK or posedge RESET) begin
      if (RESET) begin
         col1 <= '0;
         row1 <= '0;
         ox1  <= '0;
         oy1  <= '0;
         img1 <= 1'b0;
         hs1  <= HS_IDLE;
         vs1  <= VS_IDLE;
      end else begin
         col1 <= locX[12:CELL_SHIFT];
         row1 <= locY[12:CELL_SHIFT];
         ox1  <= locX[CELL_SHIFT-1:0];
         oy1  <= locY[CELL_SHIFT-1:0];
         img1 <= in_image;
         hs1  <= sync_h;
         vs1  <= sync_v;
      end
   end

   // S2 lookup: the index is only meaningful inside the grid, so the cell
   // bit is masked outside it.
   always_comb begin
      in_grid  = (col1 < PW'(GRID_W)) && (row1 < PW'(GRID_H));
      idx      = IW'(row1[RW-1:0]) * IW'(GRID_W) + IW'(col1[CW-1:0]);
      cell_bit = in_grid && cells[idx];
      border   = (ox1 == '0) || (ox1 == '1) || (oy1 == '0) || (oy1 == '1);
   end

   // S2 register: cell state and pixel classification.
   always_ff @(posedge PIXEL_CLK or posedge RESET) begin
      if (RESET) begin
         img2    <= 1'b0;
         grid2   <= 1'b0;
         border2 <= 1'b0;
         lit2    <= 1'b0;
         hs2     <= HS_IDLE;
         vs2     <= VS_IDLE;
      end else begin
         img2    <= img1;
         grid2   <= in_grid;
         border2 <= border;
         lit2    <= cell_bit;
         hs2     <= hs1;
         vs2     <= vs1;
      end
   end

   // S3: colour selection, syncs realigned with the colour.
   always_ff @(posedge PIXEL_CLK or posedge RESET) begin
      if (RESET) begin
         vga_rgb <= 8'h00;
         vga_hs  <= HS_IDLE;
         vga_vs  <= VS_IDLE;
      end else begin
         vga_hs <= hs2;
         vga_vs <= vs2;
         if (!img2 || !grid2) vga_rgb <= 8'h00;
         else if (border2)    vga_rgb <= GRID_COLOR;
         else if (lit2)       vga_rgb <= LIT_COLOR;
         else                 vga_rgb <= DARK_COLOR;
      end
   end

   // The tick marks the first line below the grid, i.e. start of blanking.
   always_comb begin
      tick   = (locX == 13'd0) && (locY == TICK_Y);
      req    = tick && (frame_cnt == 8'(FRAME_DIV - 1));
      toggle = {1'b0, lfsr[3:0]} < 5'(DENSITY);
   end

   // Frame counter keeps counting ticks even while a walk is running.
   always_ff @(posedge PIXEL_CLK or posedge RESET) begin
      if (RESET)    frame_cnt <= 8'd0;
      else if (req) frame_cnt <= 8'd0;
      else if (tick) frame_cnt <= frame_cnt + 8'd1;
   end

   // FSM state register.
   always_ff @(posedge PIXEL_CLK or posedge RESET) begin
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; freeze only gates the start of a walk.
   always_comb begin
      state_d  = state_q;
      updating = 1'b0;
      case (state_q)
         ST_IDLE: if (req && !freeze) state_d = ST_WALK;
         ST_WALK: begin
            updating = 1'b1;
            if (k == LAST) state_d = ST_DONE;
         end
         ST_DONE: begin
            updating = 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Walk datapath: cell index, LFSR and the cell array itself.
   always_ff @(posedge PIXEL_CLK or posedge RESET) begin
      if (RESET) begin
         k     <= '0;
         lfsr  <= SEED;
         cells <= CHECKER;
      end else if (state_q == ST_WALK) begin
         if (toggle) cells[k] <= ~cells[k];
         lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
         k    <= k + IW'(1);
      end else begin
         k <= '0;
      end
   end

endmodule

// File: tb/tb_blinken_render.sv
// Bench for blinken_render: three instances (default, invert-all, never
// toggle) share one stimulus stream and are checked against a frame-level
// model every cycle, plus literal spot checks.
module tb_blinken_render;

   localparam int NI = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [12:0] locX = 13'd700, locY = 13'd0;
   logic        in_image = 1'b0, sync_h = 1'b1, sync_v = 1'b1, freeze = 1'b0;

   logic [7:0] rgb0, rgb1, rgb2;
   logic       hs0, hs1, hs2, vs0, vs1, vs2, up0, up1, up2;
   logic [7:0] rgb_a [NI];
   logic       hs_a [NI], vs_a [NI], up_a [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   blinken_render u_def (
      .PIXEL_CLK(clk), .RESET(rst), .locX(locX), .locY(locY), .in_image(in_image),
      .sync_h(sync_h), .sync_v(sync_v), .freeze(freeze),
      .vga_rgb(rgb0), .vga_hs(hs0), .vga_vs(vs0), .updating(up0));

   blinken_render #(.FRAME_DIV(1), .DENSITY(16)) u_inv (
      .PIXEL_CLK(clk), .RESET(rst), .locX(locX), .locY(locY), .in_image(in_image),
      .sync_h(sync_h), .sync_v(sync_v), .freeze(freeze),
      .vga_rgb(rgb1), .vga_hs(hs1), .vga_vs(vs1), .updating(up1));

   blinken_render #(.FRAME_DIV(1), .DENSITY(0)) u_zero (
      .PIXEL_CLK(clk), .RESET(rst), .locX(locX), .locY(locY), .in_image(in_image),
      .sync_h(sync_h), .sync_v(sync_v), .freeze(freeze),
      .vga_rgb(rgb2), .vga_hs(hs2), .vga_vs(vs2), .updating(up2));

   assign rgb_a[0] = rgb0;  assign rgb_a[1] = rgb1;  assign rgb_a[2] = rgb2;
   assign hs_a[0]  = hs0;   assign hs_a[1]  = hs1;   assign hs_a[2]  = hs2;
   assign vs_a[0]  = vs0;   assign vs_a[1]  = vs1;   assign vs_a[2]  = vs2;
   assign up_a[0]  = up0;   assign up_a[1]  = up1;   assign up_a[2]  = up2;

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: whole walk applied at once on the start edge
   int         dens [NI] = '{3, 16, 0};
   int         fdv  [NI] = '{30, 1, 1};
   bit         mcell [NI][300];
   int         mcnt  [NI];
   logic [15:0] mlfsr [NI];
   int         mbusy [NI];
   logic [7:0] hrgb [NI][3];
   bit         hval [NI][3];
   logic       hhs [3], hvs [3];

   task automatic model_reset();
      for (int i = 0; i < NI; i++) begin
         for (int r = 0; r < 15; r++)
            for (int c = 0; c < 20; c++)
               mcell[i][r*20+c] = ((r + c) % 2) == 1;
         mcnt[i]  = 0;
         mlfsr[i] = 16'hACE1;
         mbusy[i] = 0;
         for (int s = 0; s < 3; s++) begin
            hrgb[i][s] = 8'h00;
            hval[i][s] = 1'b1;
         end
      end
      for (int s = 0; s < 3; s++) begin
         hhs[s] = 1'b1;
         hvs[s] = 1'b1;
      end
   endtask

   task automatic model_step();
      bit tick, idle, req, ingrid, brd;
      int col, row, ox, oy;
      logic [7:0] e;
      tick = (locX == 13'd0) && (locY == 13'd480);
      col = int'(locX) / 32;  row = int'(locY) / 32;
      ox  = int'(locX) % 32;  oy  = int'(locY) % 32;
      ingrid = (col < 20) && (row < 15);
      brd = (ox == 0) || (ox == 31) || (oy == 0) || (oy == 31);
      for (int i = 0; i < NI; i++) begin
         idle = (mbusy[i] == 0);
         if (mbusy[i] > 0) mbusy[i]--;
         if (tick) begin
            req = (mcnt[i] == fdv[i] - 1);
            mcnt[i] = req ? 0 : mcnt[i] + 1;
            if (req && !freeze && idle) begin
               for (int kk = 0; kk < 300; kk++) begin
                  if (int'(mlfsr[i][3:0]) < dens[i]) mcell[i][kk] = !mcell[i][kk];
                  mlfsr[i] = mlfsr[i][0] ? ((mlfsr[i] >> 1) ^ 16'hB400) : (mlfsr[i] >> 1);
               end
               mbusy[i] = 301;   // 300 cells plus the closing clock
            end
         end
         if (!in_image || !ingrid) e = 8'h00;
         else if (brd)             e = 8'h49;
         else if (mcell[i][row*20+col]) e = 8'hFC;
         else                      e = 8'h04;
         hrgb[i][2] = hrgb[i][1];  hrgb[i][1] = hrgb[i][0];  hrgb[i][0] = e;
         hval[i][2] = hval[i][1];  hval[i][1] = hval[i][0];  hval[i][0] = (mbusy[i] == 0);
      end
      hhs[2] = hhs[1];  hhs[1] = hhs[0];  hhs[0] = sync_h;
      hvs[2] = hvs[1];  hvs[1] = hvs[0];  hvs[0] = sync_v;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) model_reset();
      else     model_step();
   end

   // Per-cycle compare; colour is skipped while the model's walk is pending
   // because the DUT toggles cells progressively.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NI; i++) begin
         if (hval[i][2] && mbusy[i] == 0) chk($sformatf("rgb[%0d]", i), 16'(rgb_a[i]), 16'(hrgb[i][2]));
         chk($sformatf("hs[%0d]", i), 16'(hs_a[i]), 16'(hhs[2]));
         chk($sformatf("vs[%0d]", i), 16'(vs_a[i]), 16'(hvs[2]));
         chk($sformatf("upd[%0d]", i), 16'(up_a[i]), 16'(mbusy[i] > 0));
      end
   end

   // ---------------- stimulus helpers
   task automatic set_idle();
      locX = 13'd700;  locY = 13'd0;  in_image = 1'b0;
   endtask

   task automatic idle_cyc(input int n);
      for (int j = 0; j < n; j++) begin
         @(negedge clk);
         set_idle();
      end
   endtask

   task automatic tick_cyc();
      @(negedge clk);
      locX = 13'd0;  locY = 13'd480;  in_image = 1'b0;
      @(negedge clk);
      set_idle();
   endtask

   task automatic probe(input int x, input int y, input logic img,
                        input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                        input string nm);
      @(negedge clk);
      locX = 13'(x);  locY = 13'(y);  in_image = img;
      @(posedge clk);
      @(negedge clk);
      set_idle();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk({nm, "_def"},  16'(rgb0), 16'(e0));
      chk({nm, "_inv"},  16'(rgb1), 16'(e1));
      chk({nm, "_zero"}, 16'(rgb2), 16'(e2));
   endtask

   task automatic sweep();
      for (int r = 0; r < 15; r++)
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            locX = 13'(c * 32 + 16);  locY = 13'(r * 32 + 16);  in_image = 1'b1;
         end
      idle_cyc(4);
   endtask

   // Counts clocks with updating high on u_inv / u_zero, starting just after tick_cyc.
   task automatic count_walk(input int freeze_at, output int c1, output int c2);
      bool_loop: begin
         c1 = up1 ? 1 : 0;
         c2 = up2 ? 1 : 0;
         for (int n = 0; n < 400; n++) begin
            @(posedge clk);
            #1;
            if (!up1 && !up2) disable bool_loop;
            if (up1) c1++;
            if (up2) c2++;
            if (n == freeze_at) freeze = 1'b1;
         end
         chk("walk_timeout", 16'd1, 16'd0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int c1, c2;
      bit saw;
      repeat (3) @(negedge clk);
      chk("rst_rgb", 16'(rgb0), 16'h00);
      chk("rst_hs",  16'(hs0),  16'h1);
      chk("rst_vs",  16'(vs1),  16'h1);
      chk("rst_upd", 16'(up2),  16'h0);
      rst = 1'b0;
      idle_cyc(4);

      // checkerboard rendering
      probe(0, 0, 1'b1, 8'h49, 8'h49, 8'h49, "pix0_0");
      probe(40, 40, 1'b1, 8'h04, 8'h04, 8'h04, "pix40_40");
      probe(40, 8, 1'b1, 8'hFC, 8'hFC, 8'hFC, "pix40_8");
      probe(40, 8, 1'b0, 8'h00, 8'h00, 8'h00, "noimg");
      probe(650, 10, 1'b1, 8'h00, 8'h00, 8'h00, "offgrid");
      probe(639, 479, 1'b1, 8'h49, 8'h49, 8'h49, "corner");
      sweep();

      // sync edges reproduced three registers later
      @(negedge clk);
      sync_h = 1'b0;  sync_v = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("hs_fall_early", 16'(hs0), 16'h1);
      @(posedge clk); #1;
      chk("hs_fall", 16'(hs0), 16'h0);
      chk("vs_fall", 16'(vs2), 16'h0);
      @(negedge clk);
      sync_h = 1'b1;  sync_v = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("hs_rise_early", 16'(hs1), 16'h0);
      @(posedge clk); #1;
      chk("hs_rise", 16'(hs1), 16'h1);
      chk("vs_rise", 16'(vs0), 16'h1);

      // invert-all walk and never-toggle walk
      tick_cyc();
      count_walk(-1, c1, c2);
      chk("walk_len_inv", 16'(c1), 16'd301);
      chk("walk_len_zero", 16'(c2), 16'd301);
      idle_cyc(4);
      probe(8, 8, 1'b1, 8'h04, 8'hFC, 8'h04, "cell00");
      probe(40, 8, 1'b1, 8'hFC, 8'h04, 8'hFC, "cell01");
      sweep();

      // freeze drops requests
      freeze = 1'b1;
      saw = 1'b0;
      for (int t = 0; t < 3; t++) begin
         tick_cyc();
         for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            if (up0 || up1 || up2) saw = 1'b1;
         end
      end
      chk("freeze_no_walk", 16'(saw), 16'h0);
      freeze = 1'b0;
      probe(8, 8, 1'b1, 8'h04, 8'hFC, 8'h04, "frozen00");

      // freeze rising mid-walk does not cut it short
      tick_cyc();
      count_walk(8, c1, c2);
      chk("freeze_mid_len", 16'(c1), 16'd301);
      freeze = 1'b0;
      idle_cyc(4);
      probe(8, 8, 1'b1, 8'h04, 8'h04, 8'h04, "rewalk00");

      // 25 more ticks bring the default instance to its 30th
      for (int t = 0; t < 25; t++) tick_cyc();
      idle_cyc(320);
      sweep();

      // reset in the middle of a walk
      tick_cyc();
      for (int j = 0; j < 100; j++) begin
         @(negedge clk);
         locX = 13'd8;  locY = 13'd8;  in_image = 1'b1;  sync_h = 1'b0;  sync_v = 1'b0;
      end
      chk("pre_rst_upd", 16'(up1), 16'h1);
      #3;
      rst = 1'b1;
      #1;
      chk("arst_upd_inv", 16'(up1), 16'h0);
      chk("arst_upd_zero", 16'(up2), 16'h0);
      chk("arst_rgb", 16'(rgb1), 16'h00);
      chk("arst_hs", 16'(hs1), 16'h1);
      chk("arst_vs", 16'(vs2), 16'h1);
      @(negedge clk);
      @(negedge clk);
      sync_h = 1'b1;  sync_v = 1'b1;
      set_idle();
      rst = 1'b0;
      idle_cyc(3);
      probe(8, 8, 1'b1, 8'h04, 8'h04, 8'h04, "post_rst00");
      probe(40, 8, 1'b1, 8'hFC, 8'hFC, 8'hFC, "post_rst01");
      sweep();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/blinken_render.md
Name: blinken_render

Overview:
- Pixel-generation stage directly downstream of the VGA sync/timing counter.
- Consumes per-pixel coordinates, the in-image flag and the polarity-applied syncs.
- Renders a grid of square "blinkenlight" cells whose on/off states are kept in an internal bit array.
- A vertical-blank update engine randomly toggles cell states every FRAME_DIV frames.
- Emits 8-bit colour plus syncs, all delayed to stay pixel-aligned.

Parameters:
- CELL_SHIFT, 5: cell edge = 2^CELL_SHIFT pixels (32).
- GRID_W, 20: cells per row.
- GRID_H, 15: cell rows.
- FRAME_DIV, 30: frames between update walks (1..255).
- DENSITY, 3: toggle when lfsr[3:0] < DENSITY (0 = never, 16 = always).
- LFSR_SEED, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
- LIT_COLOR, 8'hFC: RRRGGGBB for a lit cell interior.
- DARK_COLOR, 8'h04: colour for a dark cell interior.
- GRID_COLOR, 8'h49: colour for cell border pixels.
- HS_IDLE, 1: vga_hs value during reset.
- VS_IDLE, 1: vga_vs value during reset.

Ports:
- PIXEL_CLK  in  1  pixel clock.
- RESET  in  1  asynchronous, active-high reset.
- locX  in  13  pixel column from the sync stage.
- locY  in  13  pixel line from the sync stage.
- in_image  in  1  pixel is in the visible area.
- sync_h  in  1  horizontal sync, polarity already applied.
- sync_v  in  1  vertical sync, polarity already applied.
- freeze  in  1  when high, update walks are skipped.
- vga_rgb  out  8  RRRGGGBB pixel colour.
- vga_hs  out  1  sync_h delayed 3 clocks.
- vga_vs  out  1  sync_v delayed 3 clocks.
- updating  out  1  high while the update walk is active.

Behaviour:
- Interface: one clock, PIXEL_CLK. RESET is asynchronous and active-high.
- Reset values:
  - vga_rgb = 0, vga_hs = HS_IDLE, vga_vs = VS_IDLE, updating = 0.
  - Every internal sync/flag pipeline register resets to its idle value.
  - lfsr = LFSR_SEED (or 1 if the seed is 0); frame counter = 0; FSM = IDLE.
  - Cell array resets to a checkerboard: cell(r,c) = (r^c)&1.
- Render pipeline, fixed latency 3:
  - S1 registers col = locX>>CELL_SHIFT, row = locY>>CELL_SHIFT, the low CELL_SHIFT bits of X and Y, in_image, sync_h, sync_v.
  - S2 computes idx = row*GRID_W+col and in_grid = (col<GRID_W)&(row<GRID_H), reads cell[idx] (0 when !in_grid), and flags border when either offset is 0 or all-ones.
  - S3 output selection:
    - !in_image or !in_grid: vga_rgb = 0.
    - border: GRID_COLOR.
    - lit cell: LIT_COLOR; dark cell: DARK_COLOR.
  - vga_hs/vga_vs are the S3 copies of sync_h/sync_v, unmodified polarity.
- Frame tick:
  - Asserted for one clock when locX==0 and locY==(GRID_H<<CELL_SHIFT), i.e. first line below the grid.
- Frame counter, 8-bit:
  - Increments on each tick.
  - On the tick where it equals FRAME_DIV-1, it returns to 0 and a walk is requested.
- FSM:
  - IDLE: on a walk request with freeze=0, go to WALK with cell index k = 0. A request with freeze=1 is dropped; the counter still wraps.
  - WALK: one cell per clock. If lfsr[3:0] < DENSITY, cell[k] toggles. The LFSR advances one step every WALK clock (Galois, taps 16'hB400). k increments; at k = GRID_W*GRID_H-1 go to DONE.
  - DONE: one clock, then IDLE.
  - updating = 1 in WALK and DONE.
  - Ticks arriving outside IDLE are ignored for walk purposes but still counted.
  - freeze rising mid-walk does not abort the walk.
- LFSR advances only in WALK, so the cell sequence is deterministic for a given seed.
- Read/write overlap: with defaults a walk (300 clocks) ends long before the image restarts. If one overlaps visible pixels, the render reads the current array; no stall or error.
- RESET mid-walk aborts immediately: every value returns to its reset value, including the checkerboard.

Test Plan:
- Reset release, then feed a 640x480 counter stream: pixel (0,0) gives GRID_COLOR 3 clocks later; pixel (40,40), cell (1,1) = 0, gives DARK_COLOR; pixel (40,8), cell (0,1) = 1, gives LIT_COLOR.
- Drive sync_h/sync_v pulses: vga_hs/vga_vs reproduce each edge exactly 3 clocks later; in_image=0 yields vga_rgb = 0 on the aligned cycle.
- DENSITY=16, FRAME_DIV=1: after the first tick, updating is high for 301 clocks and every cell is inverted; cell (0,0) now renders LIT_COLOR.
- DENSITY=0: walks run (updating pulses) and all cells remain in checkerboard.
- freeze=1 across 3 wrap ticks, FRAME_DIV=1: updating never asserts and the array is unchanged; freeze asserted 10 clocks into a walk still gives a full 301-clock walk.
- Assert RESET 100 clocks into a walk: outputs return to reset values immediately (asynchronous), the FSM is IDLE and the array is checkerboard.
